// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD converter, one bit per clock.
// Start/busy/done handshake. The output register holds the last result between
// conversions and saturates to all nines when the input does not fit in DIGITS.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits to 4'hF.
//
// Handshake: start is sampled only in IDLE; the bin sampled at that edge is
// converted. busy is high in SHIFT and DONE. done is high for exactly one cycle,
// and bcd/ovf already carry the new result in that cycle. A start that arrives
// while busy is dropped, not queued.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf,
  output logic [1:0]          o_dbg_state
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Largest value that DIGITS decimal digits can represent (10^DIGITS - 1).
  function automatic logic [63:0] max_decimal(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_decimal(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [BIN_W-1:0]   r_shreg;
  logic [BCD_W-1:0]   r_scratch;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_next;
  logic [BCD_W-1:0]   w_scr_shift;
  logic [BCD_W-1:0]   w_bcd_fmt;
  logic               w_in_ovf;
  logic               w_last_shift;

  assign w_in_ovf     = (64'(bin) > MAX_VAL);
  assign w_last_shift = (r_cnt == CNT_W'(1));
  assign o_dbg_state  = r_state;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next bin MSB.
  always_comb begin
    w_scr_shift = r_scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5) w_scr_shift[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
    end
    w_scr_shift = {w_scr_shift[BCD_W-2:0], r_shreg[BIN_W-1]};
  end

  // Final output formatting: optional leading-zero blanking, then overflow saturation.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic w_seen_nz;
    w_bcd_fmt = w_scr_shift;
    w_seen_nz = 1'b0;
    // Walk down from the top digit; digit 0 is never blanked.
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (w_scr_shift[4*d +: 4] != 4'h0) w_seen_nz = 1'b1;
      if (!w_seen_nz) w_bcd_fmt[4*d +: 4] = 4'hF;
    end
`else
    w_bcd_fmt = w_scr_shift;
`endif
    if (r_ovf_next) w_bcd_fmt = {DIGITS{4'h9}};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last_shift) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: capture on start, shift while in SHIFT, and load the result on the
  // last shift edge so bcd/ovf are already new during the DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shreg    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_next <= 1'b0;
      bcd        <= '0;
      ovf        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shreg    <= bin;
            r_scratch  <= '0;
            r_cnt      <= CNT_W'(BIN_W);
            r_ovf_next <= w_in_ovf;
          end
        end
        S_SHIFT: begin
          r_shreg   <= r_shreg << 1;
          r_scratch <= w_scr_shift;
          r_cnt     <= r_cnt - CNT_W'(1);
          if (w_last_shift) begin
            bcd <= w_bcd_fmt;
            ovf <= r_ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed scoreboard bench for bin2bcd_seq with default parameters.
// Each expected result is pushed as {done cycle, ovf, bcd} when its start is driven.
// A monitor pops an entry on every done pulse and compares it with the DUT outputs.
module tb_bin2bcd_seq;

  localparam int W = 49;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] exp_q[$];

  bin2bcd_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .bcd        (bcd),
    .ovf        (ovf),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] fmt(input logic [15:0] plain, input logic [15:0] blanked);
    return BLANK ? blanked : plain;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // Drives a one-cycle start pulse; returns the cycle index in which start was high.
  task automatic start_conv(input logic [13:0] v, input logic [15:0] e_bcd,
                            input logic e_ovf, output int t0);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    t0    = cyc;
    exp_q.push_back({32'(t0 + 15), e_ovf, e_bcd});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d bcd %h)", cyc, bcd);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), e[48:17]);
        chk("bcd", 32'(bcd), 32'(e[15:0]));
        chk("ovf", 32'(ovf), 32'(e[16]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int n_done;
    int n_busy;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle: nothing moves.
    n_done = 0;
    n_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    chk("idle_done_count", 32'(n_done), 32'd0);
    chk("idle_busy_count", 32'(n_busy), 32'd0);
    chk("reset_bcd", 32'(bcd), 32'h0000);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);

    // Basic conversion with busy window checks.
    start_conv(14'd1234, 16'h1234, 1'b0, t0);
    chk("busy_cycle1", 32'(busy), 32'd1);
    chk("done_cycle1", 32'(done), 32'd0);
    wait_cyc(t0 + 15);
    chk("busy_cycle15", 32'(busy), 32'd1);
    wait_cyc(t0 + 16);
    chk("busy_cycle16", 32'(busy), 32'd0);
    chk("done_cycle16", 32'(done), 32'd0);
    chk("bcd_hold", 32'(bcd), 32'h1234);
    wait_drain();

    start_conv(14'd42, fmt(16'h0042, 16'hFF42), 1'b0, t0);
    wait_drain();

    // Back-to-back: start held high, bin changed after the first capture.
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd9999;
    t0    = cyc;
    exp_q.push_back({32'(t0 + 15), 1'b0, 16'h9999});
    exp_q.push_back({32'(t0 + 31), 1'b0, fmt(16'h0000, 16'hFFF0)});
    @(negedge clk);
    bin = 14'd0;
    wait_cyc(t0 + 17);
    start = 1'b0;
    wait_drain();

    // Overflow saturates; a following small value clears ovf.
    start_conv(14'd10000, 16'h9999, 1'b1, t0);
    wait_drain();
    start_conv(14'd16383, 16'h9999, 1'b1, t0);
    wait_drain();
    start_conv(14'd7, fmt(16'h0007, 16'hFFF7), 1'b0, t0);
    wait_drain();

    // Start while busy is ignored; bin wiggles every cycle after capture.
    start_conv(14'd5678, 16'h5678, 1'b0, t0);
    repeat (20) begin
      bin = 14'($urandom_range(0, 16383));
      if (cyc == t0 + 5) begin
        start = 1'b1;
        bin   = 14'd1111;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);

    // Reset in the middle of a conversion aborts it.
    start_conv(14'd4321, 16'h4321, 1'b0, t0);
    void'(exp_q.pop_back());
    wait_cyc(t0 + 8);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'h0000);
    chk("abort_ovf", 32'(ovf), 32'd0);
    repeat (20) @(negedge clk);
    start_conv(14'd88, fmt(16'h0088, 16'hFF88), 1'b0, t0);
    wait_drain();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using iterative double-dabble (shift-and-add-3), one bit per clock. It sits directly upstream of the per-digit BCD-to-7-segment decoders. Each 4-bit digit slice of its output drives one decoder. Conversions use a start/busy/done handshake, and the output register holds the last result between conversions.

Parameters:
BIN_W, 14, width of binary input; must satisfy 2^BIN_W > 10^DIGITS - 1 for the overflow logic to be meaningful
DIGITS, 4, number of BCD output digits; output width 4*DIGITS

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset; one clock, synchronous, active-low
start  input  1  request conversion of bin; sampled only in IDLE
bin  input  BIN_W  unsigned binary value; captured on accepted start
busy  output  1  high while a conversion is in flight (SHIFT or DONE state)
done  output  1  one-cycle pulse; bcd/ovf valid and updated in this cycle
bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0], digit k in [4k+3:4k]
ovf  output  1  high if last converted value exceeded 10^DIGITS - 1

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE, busy=0, done=0, bcd=0, ovf=0, bit counter=0, scratch cleared. Reset mid-conversion aborts it; no done pulse follows; bcd/ovf return to 0.
- States: IDLE -> SHIFT (on start=1) -> DONE (after BIN_W shift cycles) -> IDLE (unconditional, next cycle).
- IDLE:
  - start=1 at edge: capture bin into shift register; clear BCD scratch (4*DIGITS bits); counter=BIN_W; compute ovf_next = (bin > 10^DIGITS - 1); go SHIFT.
- SHIFT, one cycle per bit:
  - every scratch digit >= 5 gets +3 (all digits in parallel, 4-bit add);
  - then {scratch, shreg} shifts left by 1, MSB of bin entering scratch bit 0;
  - counter decrements; at counter==1, go DONE.
- DONE:
  - bcd <= scratch, or all digits 4'h9 if ovf_next (saturate); ovf <= ovf_next; done=1 for exactly this cycle.
- Timing: start high in cycle 0 -> busy high cycles 1..BIN_W+1 -> done high in cycle BIN_W+1 with new bcd. Next start accepted earliest in cycle BIN_W+2. With defaults: done at cycle 15.
- start while busy is ignored; no queuing. bin changes after capture do not affect the result.
- start held high continuously yields back-to-back conversions, one per BIN_W+2 cycles.
- bcd and ovf change only in the DONE cycle; they are stable at all other times.
- Scratch never holds a digit > 9 after a shift, provided the value fits in DIGITS. On overflow, the scratch upper bits are discarded and the output saturates.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - In the DONE cycle, every digit above the most-significant nonzero digit is output as 4'hF. The downstream decoder maps non-decimal codes to all segments off.
  - Digit 0 is never blanked, so value 0 displays as "0".
  - Saturated overflow output (all 9s) is unaffected.
- Undefined: leading digits are output as 4'h0.

Test Plan:
- Reset then idle 20 cycles -> bcd=16'h0000, ovf=0, busy=0, done never asserted.
- bin=1234, start pulse at cycle 0 -> busy cycles 1..15, done only in cycle 15, bcd=16'h1234, ovf=0. With LEADING_ZERO_BLANK_EN, bin=42 -> bcd=16'hFF42 and bin=0 -> bcd=16'hFFF0.
- bin=9999 then bin=0 back-to-back (start held high) -> done at cycles 15 and 31, bcd=16'h9999 then 16'h0000.
- bin=10000 and bin=16383 -> bcd=16'h9999, ovf=1. A following bin=7 -> bcd=16'h0007, ovf=0.
- bin=5678 accepted; start pulsed at cycle 5 with bin=1111; bin input changed every cycle -> single done at cycle 15, bcd=16'h5678.
- bin=4321 accepted; rst_n=0 at cycle 8 for one cycle -> no done pulse, bcd=0, busy=0 from cycle 9. A new start with bin=88 converts normally -> bcd=16'h0088.
